nano_ctrl: RTL

Control sequencer for the 4-bit-opcode nanoprocessor datapath. Each instruction is two memory bytes: an opcode byte, whose high nibble is latched into the IR, then an operand address byte, latched into ADR. The block walks FETCH_OP -> FETCH_ADR -> EXEC and issues every datapath strobe for the 16 opcodes (NOP..JNZ). It also provides a run/halt gate at instruction boundaries and a retired-instruction counter for the disassembly/trace bench.

---
 rtl/nano_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/nano_ctrl.sv
// Control sequencer for the two-byte-instruction nanoprocessor: walks
// FETCH_OP -> FETCH_ADR -> EXEC, decodes datapath strobes and counts retirements.
module nano_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       ir_op,
    input  logic             carry,
    input  logic             zero,
    input  logic             run,
    output logic [1:0]       state,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             adr_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             acc_load,
    output logic [3:0]       alu_op,
    output logic             flags_load,
    output logic             mem_we,
    output logic             out_load,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_FETCH_OP  = 2'd0,
        S_FETCH_ADR = 2'd1,
        S_EXEC      = 2'd2,
        S_HALT      = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd10;
    localparam logic [3:0] OP_STA = 4'd11;
    localparam logic [3:0] OP_OUT = 4'd12;
    localparam logic [3:0] OP_JMP = 4'd13;
    localparam logic [3:0] OP_JNC = 4'd14;
    localparam logic [3:0] OP_JNZ = 4'd15;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state_q;

    assign state = state_q;

    // run is only honoured at instruction boundaries (FETCH_OP and HALT)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_FETCH_OP;
            instr_count <= '0;
        end else begin
            case (state_q)
                S_FETCH_OP:  state_q <= run ? S_FETCH_ADR : S_HALT;
                S_FETCH_ADR: state_q <= S_EXEC;
                S_EXEC:      state_q <= S_FETCH_OP;
                S_HALT:      state_q <= run ? S_FETCH_OP : S_HALT;
                default:     state_q <= S_FETCH_OP;
            endcase
            if (state_q == S_EXEC) begin
                instr_count <= instr_count + CNT_ONE;
            end
        end
    end

    // Strobes are gated by reset_n so a mid-instruction reset kills a pending write at once
    always_comb begin
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        adr_load   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        acc_load   = 1'b0;
        alu_op     = 4'd0;
        flags_load = 1'b0;
        mem_we     = 1'b0;
        out_load   = 1'b0;
        instr_done = 1'b0;
        if (reset_n) begin
            case (state_q)
                S_FETCH_OP: begin
                    if (run) begin
                        ir_load = 1'b1;
                        pc_inc  = 1'b1;
                    end
                end
                S_FETCH_ADR: begin
                    adr_load = 1'b1;
                    pc_inc   = 1'b1;
                end
                S_EXEC: begin
                    addr_sel   = 1'b1;
                    alu_op     = ir_op;
                    instr_done = 1'b1;
                    case (ir_op)
                        OP_NOP: ;
                        OP_LDA: acc_load = 1'b1;
                        OP_STA: mem_we   = 1'b1;
                        OP_OUT: out_load = 1'b1;
                        OP_JMP: pc_load  = 1'b1;
                        OP_JNC: pc_load  = ~carry;
                        OP_JNZ: pc_load  = ~zero;
                        default: begin
                            acc_load   = 1'b1;
                            flags_load = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
